// File: rtl/posit_regime_if.sv
// posit_regime_if
//   Bundles the upstream (scale in) and downstream (regime out) handshakes of
//   posit_regime_pipe.
//
//   Handshake rule, both sides: a transfer happens on a rising clock edge where
//   valid and ready are both high. A producer holding valid high keeps its data
//   stable until that transfer. Ready may depend on the far side's ready, never
//   on the near side's valid.
//
//   Parameters: N (posit width), ES (exponent bits), SW (scale width).
//   Upstream   : in_valid, in_ready, in_scale[SW-1:0] (signed)
//   Downstream : out_valid, out_ready, out_regime[N-2:0],
//                out_rlen[$clog2(N):0], out_exp[max(ES,1)-1:0], out_sat
//   Modports   : slave  - the regime pipe itself
//                master - whatever feeds it scales and consumes its results
`timescale 1ns/1ps
interface posit_regime_if #(
    parameter int N  = 16,
    parameter int ES = 1,
    parameter int SW = 16
);
    localparam int RLW = $clog2(N) + 1;
    localparam int EW  = (ES > 0) ? ES : 1;

    logic           in_valid;
    logic           in_ready;
    logic [SW-1:0]  in_scale;
    logic           out_valid;
    logic           out_ready;
    logic [N-2:0]   out_regime;
    logic [RLW-1:0] out_rlen;
    logic [EW-1:0]  out_exp;
    logic           out_sat;

    modport slave (
        input  in_valid, in_scale, out_ready,
        output in_ready, out_valid, out_regime, out_rlen, out_exp, out_sat
    );

    modport master (
        output in_valid, in_scale, out_ready,
        input  in_ready, out_valid, out_regime, out_rlen, out_exp, out_sat
    );
endinterface

// File: rtl/posit_regime_pipe.sv
// posit_regime_pipe
//   Two-stage pipeline that splits a signed posit scale into regime run k and
//   exponent e, then builds the MSB-aligned regime bitstring that sits below
//   the sign bit, its length (terminator included), and a saturation flag.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset; clears every valid and data reg
//     io_bus - posit_regime_if.slave (in_valid/in_ready/in_scale upstream,
//              out_valid/out_ready/out_regime/out_rlen/out_exp/out_sat down)
//
//   Stage 1 registers k = floor(scale / 2^ES), e = scale mod 2^ES, sign(k).
//   Stage 2 registers the regime pattern. Latency 2, throughput 1 per cycle.
`timescale 1ns/1ps
module posit_regime_pipe #(
    parameter int N  = 16,
    parameter int ES = 1,
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    posit_regime_if.slave io_bus
);
    localparam int RW  = N - 1;
    localparam int RLW = $clog2(N) + 1;
    localparam int EW  = (ES > 0) ? ES : 1;
    // One extra bit so the most negative scale shifts and negates cleanly.
    localparam int WK  = SW + 1;
    // Compare width: wide enough for both k and the +/-N thresholds.
    localparam int WC  = (WK > 8) ? WK : 8;

    localparam logic [EW-1:0]        E_MASK = EW'((1 << ES) - 1);
    localparam logic [RW-1:0]        MSB1   = {1'b1, {(RW-1){1'b0}}};
    localparam logic signed [WC-1:0] K_HI   = WC'(N - 2);
    localparam logic signed [WC-1:0] K_LO   = WC'(-N);
    localparam logic signed [WC-1:0] K_ONE  = WC'(1);
    localparam logic signed [WC-1:0] K_TWO  = WC'(2);

    // Handshake / advance
    logic w_adv1;
    logic w_adv2;
    logic w_accept;

    // Stage 1
    logic                 r_v1;
    logic signed [WK-1:0] r_k1;
    logic [EW-1:0]        r_e1;
    logic                 r_neg1;
    logic signed [WK-1:0] w_k0;
    logic [EW-1:0]        w_e0;

    // Stage 2
    logic                 r_v2;
    logic [RW-1:0]        r_regime2;
    logic [RLW-1:0]       r_rlen2;
    logic [EW-1:0]        r_exp2;
    logic                 r_sat2;

    // Stage 2 combinational
    logic signed [WC-1:0] w_k;
    logic signed [WC-1:0] w_m;
    logic                 w_sat_hi;
    logic                 w_sat_lo;
    logic [RLW-1:0]       w_ones;
    logic [RLW-1:0]       w_zsh;
    logic [RW-1:0]        w_regime;
    logic [RLW-1:0]       w_rlen;
    logic [EW-1:0]        w_exp;

    // An empty stage always loads, so bubbles collapse; in_ready never looks
    // at in_valid.
    assign w_adv2   = !r_v2 || io_bus.out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign w_accept = io_bus.in_valid && w_adv1;

    // Arithmetic shift of the sign-extended scale is floor division by 2^ES.
    assign w_k0 = $signed({io_bus.in_scale[SW-1], io_bus.in_scale}) >>> ES;
    assign w_e0 = io_bus.in_scale[EW-1:0] & E_MASK;

    assign w_k = WC'(r_k1);
    assign w_m = -w_k;

    assign w_sat_hi = !r_neg1 && (w_k >= K_HI);
    assign w_sat_lo =  r_neg1 && (w_k <= K_LO);

    // Positive run: min(k+1, N-1) leading ones; the terminating 0 falls out
    // of the zero fill (and drops off the end once saturated).
    assign w_ones = w_sat_hi ? RLW'(N - 1) : RLW'(w_k + K_ONE);
    // Negative run: a single 1 after min(-k, N-2) zeros. Clamping at N-2
    // yields the minpos pattern both for k = -(N-1) and for saturation.
    assign w_zsh  = (w_m >= K_HI) ? RLW'(N - 2) : RLW'(w_m);

    always_comb begin
        w_regime = '0;
        w_rlen   = '0;
        if (r_neg1) begin
            w_regime = MSB1 >> w_zsh;
            w_rlen   = w_sat_lo ? RLW'(N - 1) : RLW'(w_m + K_ONE);
        end else begin
            w_regime = ~({RW{1'b1}} >> w_ones);
            w_rlen   = w_sat_hi ? RLW'(N - 1) : RLW'(w_k + K_TWO);
        end
    end

    assign w_exp = (w_sat_hi || w_sat_lo) ? '0 : r_e1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_k1      <= '0;
            r_e1      <= '0;
            r_neg1    <= 1'b0;
            r_v2      <= 1'b0;
            r_regime2 <= '0;
            r_rlen2   <= '0;
            r_exp2    <= '0;
            r_sat2    <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= w_accept;
                if (w_accept) begin
                    r_k1   <= w_k0;
                    r_e1   <= w_e0;
                    r_neg1 <= w_k0[WK-1];
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_regime2 <= w_regime;
                    r_rlen2   <= w_rlen;
                    r_exp2    <= w_exp;
                    r_sat2    <= w_sat_hi || w_sat_lo;
                end
            end
        end
    end

    assign io_bus.in_ready   = w_adv1;
    assign io_bus.out_valid  = r_v2;
    assign io_bus.out_regime = r_regime2;
    assign io_bus.out_rlen   = r_rlen2;
    assign io_bus.out_exp    = r_exp2;
    assign io_bus.out_sat    = r_sat2;
endmodule

// File: tb/tb_posit_regime_pipe.sv
// tb_posit_regime_pipe
//   Directed bench for posit_regime_pipe. Main instance N=16 ES=1 SW=16 plus
//   three parameter variants (N=8 ES=0, N=32 ES=2, N=8 ES=4) sharing clk/rst_n.
//   Expected results are hand-computed table entries.
`timescale 1ns/1ps
module tb_posit_regime_pipe;

    localparam int NT      = 18;
    localparam int NSTREAM = 54;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    posit_regime_if #(.N(16), .ES(1), .SW(16)) bus ();
    posit_regime_if #(.N(8),  .ES(0), .SW(16)) bus_a ();
    posit_regime_if #(.N(32), .ES(2), .SW(16)) bus_b ();
    posit_regime_if #(.N(8),  .ES(4), .SW(16)) bus_c ();

    posit_regime_pipe #(.N(16), .ES(1), .SW(16)) u_dut   (.clk(clk), .rst_n(rst_n), .io_bus(bus));
    posit_regime_pipe #(.N(8),  .ES(0), .SW(16)) u_dut_a (.clk(clk), .rst_n(rst_n), .io_bus(bus_a));
    posit_regime_pipe #(.N(32), .ES(2), .SW(16)) u_dut_b (.clk(clk), .rst_n(rst_n), .io_bus(bus_b));
    posit_regime_pipe #(.N(8),  .ES(4), .SW(16)) u_dut_c (.clk(clk), .rst_n(rst_n), .io_bus(bus_c));

    logic [21:0] out_word;
    logic [12:0] out_a;
    logic [39:0] out_b;
    logic [15:0] out_c;

    assign out_word = {bus.out_regime, bus.out_rlen, bus.out_exp, bus.out_sat};
    assign out_a    = {bus_a.out_regime, bus_a.out_rlen, bus_a.out_exp, bus_a.out_sat};
    assign out_b    = {bus_b.out_regime, bus_b.out_rlen, bus_b.out_exp, bus_b.out_sat};
    assign out_c    = {bus_c.out_regime, bus_c.out_rlen, bus_c.out_exp, bus_c.out_sat};

    // ---------------- scoreboard state ----------------
    int          n_vec;
    int          n_err;
    logic [21:0] exp_q[$];
    int          sent;
    int          got;
    logic        acc;
    logic        drn;
    logic        hold_v;
    logic [21:0] hold_w;

    function automatic logic [21:0] mk16(input logic [14:0] r, input logic [4:0] l,
                                         input logic e, input logic s);
        return {r, l, e, s};
    endfunction

    // N=16 ES=1 table: scale -> {regime, rlen, exp, sat}
    logic [15:0] tbl_s [NT];
    logic [21:0] tbl_w [NT];

    // Parameter-variant tables
    logic [15:0] sw_s_a [4];
    logic [15:0] sw_s_b [4];
    logic [15:0] sw_s_c [4];
    logic [12:0] sw_w_a [4];
    logic [39:0] sw_w_b [4];
    logic [15:0] sw_w_c [4];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Send one scale with out_ready high and check the 2-cycle latency.
    task automatic run_single(input int idx);
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_scale  = tbl_s[idx];
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_val($sformatf("lat1_valid[%0d]", idx), bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check_val($sformatf("lat2_valid[%0d]", idx), bus.out_valid, 1'b1);
        check_val($sformatf("result[%0d]", idx), out_word, tbl_w[idx]);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        tbl_s = '{16'sd0, 16'sd5, -16'sd3, 16'sd27, 16'sd28, -16'sd32, 16'h8000,
                  16'sd1, -16'sd1, -16'sd30, -16'sd29, -16'sd28, -16'sd2, 16'sd32767,
                  16'sd10, -16'sd31, 16'sd26, 16'sd29};
        tbl_w = '{mk16(15'h4000, 5'd2,  1'b0, 1'b0),
                  mk16(15'h7000, 5'd4,  1'b1, 1'b0),
                  mk16(15'h1000, 5'd3,  1'b1, 1'b0),
                  mk16(15'h7FFE, 5'd15, 1'b1, 1'b0),
                  mk16(15'h7FFF, 5'd15, 1'b0, 1'b1),
                  mk16(15'h0001, 5'd15, 1'b0, 1'b1),
                  mk16(15'h0001, 5'd15, 1'b0, 1'b1),
                  mk16(15'h4000, 5'd2,  1'b1, 1'b0),
                  mk16(15'h2000, 5'd2,  1'b1, 1'b0),
                  mk16(15'h0001, 5'd16, 1'b0, 1'b0),
                  mk16(15'h0001, 5'd16, 1'b1, 1'b0),
                  mk16(15'h0001, 5'd15, 1'b0, 1'b0),
                  mk16(15'h2000, 5'd2,  1'b0, 1'b0),
                  mk16(15'h7FFF, 5'd15, 1'b0, 1'b1),
                  mk16(15'h7E00, 5'd7,  1'b0, 1'b0),
                  mk16(15'h0001, 5'd15, 1'b0, 1'b1),
                  mk16(15'h7FFE, 5'd15, 1'b0, 1'b0),
                  mk16(15'h7FFF, 5'd15, 1'b0, 1'b1)};

        sw_s_a = '{16'sd6, -16'sd7, 16'sd3, -16'sd1};
        sw_w_a = '{{7'h7F, 4'd7, 1'b0, 1'b1},
                   {7'h01, 4'd8, 1'b0, 1'b0},
                   {7'h78, 4'd5, 1'b0, 1'b0},
                   {7'h20, 4'd2, 1'b0, 1'b0}};
        sw_s_b = '{16'sd13, -16'sd9, 16'sd121, -16'sd125};
        sw_w_b = '{{31'h7800_0000, 6'd5,  2'd1, 1'b0},
                   {31'h0800_0000, 6'd4,  2'd3, 1'b0},
                   {31'h7FFF_FFFF, 6'd31, 2'd0, 1'b1},
                   {31'h0000_0001, 6'd31, 2'd0, 1'b1}};
        sw_s_c = '{16'sd37, -16'sd17, 16'sd100, -16'sd1000};
        sw_w_c = '{{7'h70, 4'd4, 4'd5,  1'b0},
                   {7'h10, 4'd3, 4'd15, 1'b0},
                   {7'h7F, 4'd7, 4'd0,  1'b1},
                   {7'h01, 4'd7, 4'd0,  1'b1}};

        bus.in_valid    = 1'b0;
        bus.in_scale    = '0;
        bus.out_ready   = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.in_scale  = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_scale  = '0;
        bus_b.out_ready = 1'b1;
        bus_c.in_valid  = 1'b0;
        bus_c.in_scale  = '0;
        bus_c.out_ready = 1'b1;

        // ---------------- reset values ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", bus.out_valid, 1'b0);
        check_val("rst_out_regime", bus.out_regime, 15'h0);
        check_val("rst_out_rlen", bus.out_rlen, 5'd0);
        check_val("rst_out_exp", bus.out_exp, 1'b0);
        check_val("rst_out_sat", bus.out_sat, 1'b0);
        check_val("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;

        // ---------------- directed single vectors ----------------
        for (int i = 0; i < NT; i++) run_single(i);

        // ---------------- backpressure ----------------
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_scale  = tbl_s[0];
        @(posedge clk); #1;
        check_val("bp_rdy_after1", bus.in_ready, 1'b1);
        bus.in_scale = tbl_s[1];
        @(posedge clk); #1;
        bus.in_scale = tbl_s[2];
        check_val("bp_rdy_full", bus.in_ready, 1'b0);
        check_val("bp_valid", bus.out_valid, 1'b1);
        check_val("bp_hold_regime", bus.out_regime, 15'h4000);
        @(posedge clk); #1;
        check_val("bp_still_full", bus.in_ready, 1'b0);
        check_val("bp_hold_word", out_word, tbl_w[0]);
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_rdy_comb", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_val("bp_drain1", out_word, tbl_w[1]);
        check_val("bp_drain1_valid", bus.out_valid, 1'b1);
        @(posedge clk); #1;
        check_val("bp_drain2", out_word, tbl_w[2]);
        check_val("bp_drain2_valid", bus.out_valid, 1'b1);
        @(posedge clk); #1;
        check_val("bp_empty", bus.out_valid, 1'b0);

        // ---------------- streaming with random valid/ready ----------------
        sent   = 0;
        got    = 0;
        hold_v = 1'b0;
        hold_w = '0;
        for (int cyc = 0; cyc < 3000 && got < NSTREAM; cyc++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            drn = bus.out_valid && bus.out_ready;
            if (hold_v) begin
                check_val("stall_valid", bus.out_valid, 1'b1);
                check_val("stall_hold", out_word, hold_w);
            end
            if (acc) begin
                exp_q.push_back(tbl_w[sent % NT]);
                sent++;
            end
            if (drn) begin
                check_val("q_nonempty", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) check_val("stream", out_word, exp_q.pop_front());
                got++;
            end
            hold_v = bus.out_valid && !bus.out_ready;
            hold_w = out_word;
            @(posedge clk); #1;
            if (acc || !bus.in_valid) begin
                if (sent < NSTREAM && $urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_scale = tbl_s[sent % NT];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        check_val("stream_count", got, NSTREAM);
        check_val("stream_q_empty", exp_q.size(), 0);

        // ---------------- reset mid-flight ----------------
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_scale  = tbl_s[1];
        @(posedge clk); #1;
        bus.in_scale = tbl_s[2];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_val("mid_inflight_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", bus.out_valid, 1'b0);
        check_val("mid_rst_regime", bus.out_regime, 15'h0);
        check_val("mid_rst_rlen", bus.out_rlen, 5'd0);
        check_val("mid_rst_exp", bus.out_exp, 1'b0);
        check_val("mid_rst_sat", bus.out_sat, 1'b0);
        check_val("mid_rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("mid_no_stale", bus.out_valid, 1'b0);
        end

        // ---------------- parameter variants ----------------
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus_a.in_valid = 1'b1;
            bus_a.in_scale = sw_s_a[i];
            bus_b.in_valid = 1'b1;
            bus_b.in_scale = sw_s_b[i];
            bus_c.in_valid = 1'b1;
            bus_c.in_scale = sw_s_c[i];
            @(posedge clk); #1;
            bus_a.in_valid = 1'b0;
            bus_b.in_valid = 1'b0;
            bus_c.in_valid = 1'b0;
            @(posedge clk); #1;
            check_val($sformatf("n8e0_valid[%0d]", i), bus_a.out_valid, 1'b1);
            check_val($sformatf("n8e0[%0d]", i), out_a, sw_w_a[i]);
            check_val($sformatf("n32e2_valid[%0d]", i), bus_b.out_valid, 1'b1);
            check_val($sformatf("n32e2[%0d]", i), out_b, sw_w_b[i]);
            check_val($sformatf("n8e4_valid[%0d]", i), bus_c.out_valid, 1'b1);
            check_val($sformatf("n8e4[%0d]", i), out_c, sw_w_c[i]);
        end

        // ---------------- report ----------------
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/posit_regime_pipe.md
Name: posit_regime_pipe

Overview:
- Pipelined, parametrised posit regime/exponent field generator.
- Takes a signed posit scale value and splits it into regime run k and exponent field e (ES bits).
- Emits the MSB-aligned regime bitstring in the N-1 bits below the sign, plus run length, exponent and saturation flag.
- Sits between the float-to-posit scale computation and the final posit packer; valid/ready on both sides, 2-cycle latency.

Parameters:
- N, 16, posit width in bits including sign; legal range 4..32.
- ES, 1, exponent field width; legal range 0..4.
- SW, 16, width of the signed input scale.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input scale valid.
- in_ready  output  1  block can accept input this cycle.
- in_scale  input  SW  signed scale, two's complement.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_regime  output  N-1  regime bits, MSB-aligned, zero-filled below the terminator.
- out_rlen  output  $clog2(N)+1  regime length including terminator.
- out_exp  output  ES (min 1)  exponent field e; 0 when ES=0.
- out_sat  output  1  regime saturated (maxpos or minpos pattern).

Behaviour:
- Reset values:
  - All valid flags 0, all data registers 0.
  - Hence out_valid=0, out_regime=0, out_rlen=0, out_exp=0, out_sat=0, in_ready=1.
- Stage 1 (registered on accept):
  - k = in_scale >>> ES (arithmetic, i.e. floor division).
  - e = in_scale[ES-1:0].
  - Register k, e and sign(k).
- Stage 2 (registered):
  - k >= 0 and k <= N-3:
    - regime = (k+1) ones followed by one 0, MSB-aligned in N-1 bits.
    - rlen = k+2, sat=0.
  - k < 0 and k >= -(N-1):
    - regime = (-k) zeros followed by one 1.
    - rlen = -k+1, sat=0.
  - k >= N-2:
    - regime = all ones (N-1 bits).
    - rlen = N-1, sat=1, exp forced to 0.
  - k <= -N:
    - regime = N-2 zeros then a 1.
    - rlen = N-1, sat=1, exp forced to 0.
  - k = -(N-1) produces the minpos pattern naturally: rlen = N, sat=0. rlen is an unclamped count; the packer uses it.
- Width rules:
  - Shift and compare logic uses SW+1 bits to avoid overflow on the most negative in_scale.
  - No truncation of k before the saturation compare.
- Handshake:
  - Per-stage valid v1, v2.
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1. Combinational from out_ready; no path from in_valid.
  - Input accepted when in_valid & in_ready.
  - Bubbles collapse: an empty stage always loads.
- Latency and throughput:
  - Latency: input accepted at cycle t appears with out_valid=1 at cycle t+2 if not stalled.
  - Throughput: 1 per cycle.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold stable.
- Full/empty:
  - Full: both stages valid and out_ready=0, so in_ready=0.
  - Simultaneous accept and drain in the same cycle is lossless.
- Reset asserted mid-operation: all in-flight data is discarded asynchronously; outputs return to reset values immediately.

Test Plan:
- Basic (N=16, ES=1):
  - in_scale=0 -> 2 cycles later out_regime=15'h4000, out_rlen=2, out_exp=0, out_sat=0.
  - in_scale=5 (k=2, e=1) -> out_regime=15'h7000, out_rlen=4, out_exp=1, out_sat=0.
  - in_scale=-3 (k=-2, e=1) -> out_regime=15'h1000, out_rlen=3, out_exp=1, out_sat=0.
- Saturation and boundaries:
  - in_scale=27 (k=13) -> 15'h7FFE, rlen=15, sat=0.
  - in_scale=28 (k=14) -> 15'h7FFF, rlen=15, sat=1, exp=0.
  - in_scale=-32 (k=-16) -> 15'h0001, rlen=15, sat=1.
  - in_scale=-32768 -> same as -32, no overflow.
- Backpressure:
  - Stimulus: stream 0, 5, -3 back-to-back with out_ready=0 from first accept.
  - Required: in_ready drops after 2 accepts; third input held; out_regime stays 15'h4000.
  - Then raise out_ready: results emerge in order 4000, 7000, 1000 on consecutive cycles, none lost or duplicated.
- Streaming: random in_scale, random in_valid and out_ready toggling -> output sequence matches a reference model in order; out_* stable during every stall.
- Reset mid-flight: 2 items in flight, pull rst_n low asynchronously between edges -> out_valid=0 and all outputs 0 immediately, in_ready=1; after release, no stale result appears.
- Parameter sweep: N=8 ES=0, N=32 ES=2, N=8 ES=4.
  - N=8, ES=0, in_scale=6 -> k=6 >= N-2, 7'h7F, sat=1.
  - N=8, ES=0, in_scale=-7 -> 7'h01, rlen=8, sat=0.
